// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU data-memory path: access sizes, memory FSM
// encoding and the response record carried down the read-latency pipeline.
package cpu_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  typedef struct packed {
    logic       valid;
    logic       error;
    logic       write;
    logic [1:0] offset;
    logic [1:0] size;
    logic       is_unsigned;
  } resp_t;

  // Misaligned halves/words and the reserved size encoding are rejected.
  function automatic logic access_error(input logic [1:0] size, input logic [1:0] offset);
    logic err;
    case (size)
      SIZE_BYTE: err = 1'b0;
      SIZE_HALF: err = offset[0];
      SIZE_WORD: err = |offset;
      default:   err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load alignment: shifts the addressed byte/half/word down to bit 0 and
// sign- or zero-extends it to 32 bits. Shared with the MMIO read path.
module dmem_load_align
  import cpu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] data
);

  logic [31:0] shifted;

  assign shifted = word >> {offset, 3'b000};

  always_comb begin
    data = '0;
    case (size)
      SIZE_BYTE: data = is_unsigned ? {24'h0, shifted[7:0]}
                                    : {{24{shifted[7]}}, shifted[7:0]};
      SIZE_HALF: data = is_unsigned ? {16'h0, shifted[15:0]}
                                    : {{16{shifted[15]}}, shifted[15:0]};
      SIZE_WORD: data = shifted;
      default:   data = '0;
    endcase
  end

endmodule

// File: rtl/dmem_sized.sv
// Word-organised data RAM with byte/half/word access, fixed-latency
// request/response handshake and an optional zero-fill sweep after reset.
module dmem_sized
  import cpu_pkg::*;
#(
  parameter int ADDR_WIDTH     = 14,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic        resp_valid,
  output logic        resp_error,
  output logic [31:0] read_data
);

  localparam int DEPTH      = 2 ** ADDR_WIDTH;
  localparam int BYTE_LANES = 4;

  logic [31:0] mem [DEPTH];

  logic [0:0]            state_reg, state_next;
  logic [ADDR_WIDTH-1:0] clear_cnt_reg, clear_cnt_next;

  logic [ADDR_WIDTH-1:0] req_index;
  logic [1:0]            req_offset;
  logic                  req_err;
  logic                  accept;
  logic                  clearing;
  logic                  store_ok;
  logic                  load_en;
  logic [3:0]            req_lanes;
  logic [31:0]           store_rep;
  logic [3:0]            wr_lane;
  logic [31:0]           wr_data;
  logic [ADDR_WIDTH-1:0] wr_index;
  logic [31:0]           rd_word_reg;
  logic [31:0]           out_word;
  logic [31:0]           aligned;
  logic                  unused_addr_bits;

  resp_t resp_in;
  resp_t out_resp;
  resp_t resp_pipe_reg [READ_LATENCY];

  assign req_index        = address[ADDR_WIDTH+1:2];
  assign req_offset       = address[1:0];
  assign unused_addr_bits = ^address[31:ADDR_WIDTH+2];

  // Gating with reset keeps a request in a reset cycle from being taken.
  assign req_ready = (state_reg == ST_RUN) && !reset;
  assign accept    = req_valid && req_ready;
  assign clearing  = (state_reg == ST_CLEAR) && !reset;
  assign req_err   = access_error(req_size, req_offset);
  assign store_ok  = accept && req_write && !req_err;
  assign load_en   = accept && !req_write && !req_err;

  always_comb begin
    req_lanes = 4'b0000;
    store_rep = write_data;
    case (req_size)
      SIZE_BYTE: begin
        req_lanes = 4'b0001 << req_offset;
        store_rep = {4{write_data[7:0]}};
      end
      SIZE_HALF: begin
        req_lanes = req_offset[1] ? 4'b1100 : 4'b0011;
        store_rep = {2{write_data[15:0]}};
      end
      SIZE_WORD: req_lanes = 4'b1111;
      default:   req_lanes = 4'b0000;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < BYTE_LANES; gi++) begin : g_lane
      assign wr_lane[gi]          = clearing || (store_ok && req_lanes[gi]);
      assign wr_data[8*gi +: 8]   = clearing ? 8'h00 : store_rep[8*gi +: 8];
    end
  endgenerate

  assign wr_index = clearing ? clear_cnt_reg : req_index;

  always_ff @(posedge clock) begin
    for (int b = 0; b < BYTE_LANES; b++) begin
      if (wr_lane[b]) mem[wr_index][8*b +: 8] <= wr_data[8*b +: 8];
    end
    if (load_en) rd_word_reg <= mem[req_index];
  end

  always_comb begin
    state_next     = state_reg;
    clear_cnt_next = clear_cnt_reg;
    if (state_reg == ST_CLEAR) begin
      clear_cnt_next = clear_cnt_reg + 1'b1;
      if (clear_cnt_reg == {ADDR_WIDTH{1'b1}}) state_next = ST_RUN;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
      clear_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      clear_cnt_reg <= clear_cnt_next;
    end
  end

  assign resp_in = '{valid: accept, error: req_err, write: req_write,
                     offset: req_offset, size: req_size, is_unsigned: req_unsigned};

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < READ_LATENCY; i++) resp_pipe_reg[i] <= '0;
    end else begin
      resp_pipe_reg[0] <= resp_in;
      for (int i = 1; i < READ_LATENCY; i++) resp_pipe_reg[i] <= resp_pipe_reg[i-1];
    end
  end

  // Stage 0 of the data path is the RAM output register itself.
  generate
    if (READ_LATENCY > 1) begin : g_word_delay
      logic [31:0] word_dly_reg [READ_LATENCY-1];
      always_ff @(posedge clock) begin
        word_dly_reg[0] <= rd_word_reg;
        for (int i = 1; i < READ_LATENCY - 1; i++) word_dly_reg[i] <= word_dly_reg[i-1];
      end
      assign out_word = word_dly_reg[READ_LATENCY-2];
    end else begin : g_word_direct
      assign out_word = rd_word_reg;
    end
  endgenerate

  assign out_resp = resp_pipe_reg[READ_LATENCY-1];

  dmem_load_align u_align (
    .word        (out_word),
    .offset      (out_resp.offset),
    .size        (out_resp.size),
    .is_unsigned (out_resp.is_unsigned),
    .data        (aligned)
  );

  assign resp_valid = out_resp.valid;
  assign resp_error = out_resp.valid && out_resp.error;
  assign read_data  = (out_resp.valid && !out_resp.error && !out_resp.write) ? aligned : 32'h0;

endmodule

// File: tb/tb_dmem_sized.sv
// Directed bench for dmem_sized: ADDR_WIDTH=4, READ_LATENCY=3, CLEAR_ON_RESET=1.
module tb_dmem_sized;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] address;
  logic [31:0] write_data;
  logic        resp_valid;
  logic        resp_error;
  logic [31:0] read_data;

  int checks = 0;
  int errors = 0;

  dmem_sized #(.ADDR_WIDTH(4), .READ_LATENCY(3), .CLEAR_ON_RESET(1)) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .address      (address),
    .write_data   (write_data),
    .resp_valid   (resp_valid),
    .resp_error   (resp_error),
    .read_data    (read_data)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exhausted, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // Issues one request and waits (bounded) for its response.
  task automatic do_req(input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output int lat, output logic err, output logic [31:0] rd);
    int c;
    lat = -1; err = 1'b0; rd = 32'h0;
    req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
    address = addr; write_data = wd;
    c = 0;
    while (lat < 0 && c < 8) begin
      @(negedge clock);
      c++;
      if (c == 1) req_valid = 1'b0;
      if (resp_valid) begin
        lat = c; err = resp_error; rd = read_data;
      end
    end
    $display("req wr=%0d size=%0d uns=%0d addr=%h wdata=%h -> lat=%0d err=%0d rdata=%h",
             wr, sz, uns, addr, wd, lat, err, rd);
  endtask

  task automatic count_not_ready(output int n);
    n = 0;
    while (!req_ready && n < 200) begin
      n++;
      @(negedge clock);
    end
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; address = 32'h0; write_data = 32'h0;
    repeat (3) @(negedge clock);
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
    checks++; if (resp_error !== 1'b0) begin errors++; $display("FAIL reset_resp_error: got %b expected 0", resp_error); end
    checks++; if (read_data !== 32'h0) begin errors++; $display("FAIL reset_read_data: got %h expected 00000000", read_data); end
    reset = 1'b0;
    #1;
    count_not_ready(n);
    $display("clear sweep: ready low for %0d cycles", n);
    checks++; if (n != 16) begin errors++; $display("FAIL clear_cycles: got %0d expected 16", n); end
  endtask

  task automatic test_clear_restart();
    int lat, n;
    logic err;
    logic [31:0] rd;
    for (int i = 0; i < 16; i++) do_req(1'b1, 2'b10, 1'b0, 32'(4 * i), 32'hA500_0000 | 32'(i), lat, err, rd);
    reset = 1'b1; @(negedge clock); reset = 1'b0;
    repeat (5) @(negedge clock);
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL mid_clear_ready: got %b expected 0", req_ready); end
    reset = 1'b1; @(negedge clock); reset = 1'b0;
    #1;
    count_not_ready(n);
    $display("restarted sweep: ready low for %0d cycles", n);
    checks++; if (n != 16) begin errors++; $display("FAIL restart_cycles: got %0d expected 16", n); end
    for (int i = 0; i < 16; i++) begin
      do_req(1'b0, 2'b10, 1'b0, 32'(4 * i), 32'h0, lat, err, rd);
      checks++; if (lat != 3 || err !== 1'b0 || rd !== 32'h0) begin
        errors++; $display("FAIL clear_word%0d: got lat=%0d err=%b data=%h expected lat=3 err=0 data=00000000", i, lat, err, rd);
      end
    end
  endtask

  task automatic test_bytes();
    int lat;
    logic err;
    logic [31:0] rd;
    logic [31:0] exp_s [4];
    logic [31:0] exp_u [4];
    exp_s = '{32'hFFFF_FFFF, 32'h0000_0022, 32'h0000_0044, 32'hFFFF_FF88};
    exp_u = '{32'h0000_00FF, 32'h0000_0022, 32'h0000_0044, 32'h0000_0088};
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h8844_22FF, lat, err, rd);
    checks++; if (lat != 3 || err !== 1'b0 || rd !== 32'h0) begin
      errors++; $display("FAIL store_resp: got lat=%0d err=%b data=%h expected lat=3 err=0 data=00000000", lat, err, rd);
    end
    for (int i = 0; i < 4; i++) begin
      do_req(1'b0, 2'b00, 1'b0, 32'h10 + 32'(i), 32'h0, lat, err, rd);
      checks++; if (lat != 3 || err !== 1'b0 || rd !== exp_s[i]) begin
        errors++; $display("FAIL lb_signed@%0d: got lat=%0d err=%b data=%h expected lat=3 err=0 data=%h", i, lat, err, rd, exp_s[i]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      do_req(1'b0, 2'b00, 1'b1, 32'h10 + 32'(i), 32'h0, lat, err, rd);
      checks++; if (lat != 3 || err !== 1'b0 || rd !== exp_u[i]) begin
        errors++; $display("FAIL lb_unsigned@%0d: got lat=%0d err=%b data=%h expected lat=3 err=0 data=%h", i, lat, err, rd, exp_u[i]);
      end
    end
  endtask

  task automatic test_merge();
    int lat;
    logic err;
    logic [31:0] rd;
    do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'h1122_3344, lat, err, rd);
    do_req(1'b1, 2'b00, 1'b0, 32'h21, 32'hFFFF_FFAB, lat, err, rd);
    do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, lat, err, rd);
    checks++; if (err !== 1'b0 || rd !== 32'h1122_AB44) begin errors++; $display("FAIL byte_merge: got err=%b data=%h expected err=0 data=1122ab44", err, rd); end
    do_req(1'b1, 2'b01, 1'b0, 32'h22, 32'h0000_8000, lat, err, rd);
    do_req(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, lat, err, rd);
    checks++; if (err !== 1'b0 || rd !== 32'hFFFF_8000) begin errors++; $display("FAIL lh_signed: got err=%b data=%h expected err=0 data=ffff8000", err, rd); end
    do_req(1'b0, 2'b01, 1'b1, 32'h22, 32'h0, lat, err, rd);
    checks++; if (err !== 1'b0 || rd !== 32'h0000_8000) begin errors++; $display("FAIL lh_unsigned: got err=%b data=%h expected err=0 data=00008000", err, rd); end
    do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, lat, err, rd);
    checks++; if (err !== 1'b0 || rd !== 32'h8000_AB44) begin errors++; $display("FAIL half_merge: got err=%b data=%h expected err=0 data=8000ab44", err, rd); end
  endtask

  task automatic test_misaligned();
    int lat;
    logic err;
    logic [31:0] rd;
    do_req(1'b1, 2'b10, 1'b0, 32'h13, 32'h1234_5678, lat, err, rd);
    checks++; if (lat != 3 || err !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL sw_misaligned: got lat=%0d err=%b data=%h expected lat=3 err=1 data=00000000", lat, err, rd); end
    do_req(1'b0, 2'b01, 1'b0, 32'h15, 32'h0, lat, err, rd);
    checks++; if (lat != 3 || err !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL lh_misaligned: got lat=%0d err=%b data=%h expected lat=3 err=1 data=00000000", lat, err, rd); end
    do_req(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, lat, err, rd);
    checks++; if (lat != 3 || err !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL load_size11: got lat=%0d err=%b data=%h expected lat=3 err=1 data=00000000", lat, err, rd); end
    do_req(1'b1, 2'b11, 1'b0, 32'h10, 32'h0000_0000, lat, err, rd);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL store_size11: got err=%b expected err=1", err); end
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, err, rd);
    checks++; if (err !== 1'b0 || rd !== 32'h8844_22FF) begin errors++; $display("FAIL word10_intact: got err=%b data=%h expected err=0 data=884422ff", err, rd); end
  endtask

  task automatic test_wrap();
    int lat;
    logic err;
    logic [31:0] rd;
    do_req(1'b0, 2'b10, 1'b0, 32'h50, 32'h0, lat, err, rd);
    checks++; if (err !== 1'b0 || rd !== 32'h8844_22FF) begin errors++; $display("FAIL wrap_load: got err=%b data=%h expected err=0 data=884422ff", err, rd); end
    do_req(1'b1, 2'b10, 1'b0, 32'hFFFF_FF44, 32'h0BAD_F00D, lat, err, rd);
    do_req(1'b0, 2'b10, 1'b0, 32'h04, 32'h0, lat, err, rd);
    checks++; if (err !== 1'b0 || rd !== 32'h0BAD_F00D) begin errors++; $display("FAIL wrap_store: got err=%b data=%h expected err=0 data=0badf00d", err, rd); end
  endtask

  task automatic test_back_to_back();
    logic        wr_t  [4];
    logic [1:0]  sz_t  [4];
    logic        un_t  [4];
    logic [31:0] ad_t  [4];
    logic [31:0] exp_t [4];
    int          cyc_got [4];
    logic [31:0] rd_got  [4];
    logic        err_got [4];
    int n;
    wr_t  = '{1'b1, 1'b0, 1'b0, 1'b0};
    sz_t  = '{2'b10, 2'b10, 2'b00, 2'b01};
    un_t  = '{1'b0, 1'b0, 1'b1, 1'b0};
    ad_t  = '{32'h30, 32'h30, 32'h31, 32'h32};
    exp_t = '{32'h0, 32'hCAFE_F00D, 32'h0000_00F0, 32'hFFFF_CAFE};
    n = 0;
    for (int c = 0; c < 12; c++) begin
      if (c > 0 && resp_valid) begin
        if (n < 4) begin
          cyc_got[n] = c; rd_got[n] = read_data; err_got[n] = resp_error;
          $display("b2b resp %0d at cycle %0d err=%0d rdata=%h", n, c, resp_error, read_data);
        end
        n++;
      end
      if (c < 4) begin
        req_valid = 1'b1; req_write = wr_t[c]; req_size = sz_t[c]; req_unsigned = un_t[c];
        address = ad_t[c]; write_data = 32'hCAFE_F00D;
      end else begin
        req_valid = 1'b0;
      end
      @(negedge clock);
    end
    checks++; if (n != 4) begin errors++; $display("FAIL b2b_count: got %0d expected 4", n); end
    for (int i = 0; i < 4; i++) begin
      if (i < n) begin
        checks++; if (cyc_got[i] != i + 3 || err_got[i] !== 1'b0 || rd_got[i] !== exp_t[i]) begin
          errors++; $display("FAIL b2b_resp%0d: got cycle=%0d err=%b data=%h expected cycle=%0d err=0 data=%h",
                             i, cyc_got[i], err_got[i], rd_got[i], i + 3, exp_t[i]);
        end
      end
    end
  endtask

  task automatic test_reset_inflight();
    int lat, n, seen;
    logic err;
    logic [31:0] rd;
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; address = 32'h30;
    @(negedge clock);
    address = 32'h04;
    @(negedge clock);
    req_valid = 1'b0; reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      if (resp_valid) seen++;
      @(negedge clock);
    end
    $display("reset in flight: %0d responses after reset", seen);
    checks++; if (seen != 0) begin errors++; $display("FAIL inflight_dropped: got %0d responses expected 0", seen); end
    count_not_ready(n);
    do_req(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, lat, err, rd);
    checks++; if (lat != 3 || err !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL post_reset_clear: got lat=%0d err=%b data=%h expected lat=3 err=0 data=00000000", lat, err, rd); end
  endtask

  initial begin
    test_reset();
    test_clear_restart();
    test_bytes();
    test_merge();
    test_misaligned();
    test_wrap();
    test_back_to_back();
    test_reset_inflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_sized.md
Name: dmem_sized

Overview:
- Parametrised data memory for the single-cycle/multicycle CPU datapath; next generation of the 32-bit word-only data RAM wrapper.
- Adds byte/halfword/word loads and stores with byte-lane enables, sign/zero extension and misalignment detection.
- Adds a request/response handshake with configurable read latency and an optional post-reset zero-clear sweep.
- Storage is an inferred array (no IP core), word-organised, BYTE_LANES bytes per word.

Parameters:
- ADDR_WIDTH, 14, word-index bits; depth = 2**ADDR_WIDTH words.
- READ_LATENCY, 1, cycles from request accept to resp_valid; legal 1..3.
- CLEAR_ON_RESET, 1, 1 = zero every word after reset before accepting requests; 0 = contents undefined, ready immediately.

Ports:
- clock  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- address  in  32  byte address; word index = address[ADDR_WIDTH+1:2]; higher bits ignored.
- write_data  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- resp_valid  out  1  one-cycle pulse per accepted request.
- resp_error  out  1  valid with resp_valid; 1 = misaligned or reserved size.
- read_data  out  32  extended load result; 0 for stores and errors.

Behaviour:
- Reset values: req_ready=0, resp_valid=0, resp_error=0, read_data=0. All pipeline valid bits cleared; in-flight responses dropped. A request presented in a reset cycle is not accepted and is not written.
- FSM states:
  - CLEAR: entered on reset when CLEAR_ON_RESET=1. A counter sweeps word 0..depth-1, writing 0 one word per cycle; req_ready=0. After the last word, go to RUN. Sweep takes 2**ADDR_WIDTH cycles.
  - RUN: req_ready=1 every cycle. Reset during CLEAR restarts the sweep at word 0. With CLEAR_ON_RESET=0, the first cycle after reset deasserts is RUN.
- Accept = req_valid && req_ready. No response back-pressure; one request per cycle sustained.
- Error check:
  - half with address[0]=1 -> error.
  - word with address[1:0]!=0 -> error.
  - size 11 -> error.
  - On error: no memory write, read_data=0, resp_error=1.
- Store: byte lane = address[1:0] for byte stores, address[1] selects the half for half stores. write_data is replicated into the lane and only the enabled lanes are written on the accept edge. Other bytes are preserved.
- Load: word read registered on the accept edge. Offset, size, unsigned and error are carried alongside. Data is shifted right by 8*offset and extended to 32 bits.
- Latency: resp_valid asserts exactly READ_LATENCY cycles after the accept edge, for both stores and loads. Extra stages for READ_LATENCY>1 are plain registers.
- Ordering: responses are returned in request order.
- Same-word hazard: a load accepted the cycle after a store to the same word returns the new data, since the write commits on the earlier edge. A load and store cannot occur in the same cycle (single port).
- Address wrap: bits above ADDR_WIDTH+1 are ignored, so address 4*depth aliases word 0.

Decomposition:
- Shared package (cpu_pkg) holds:
  - size encodings SIZE_BYTE=2'b00, SIZE_HALF=2'b01, SIZE_WORD=2'b10;
  - the FSM state encoding CLEAR/RUN;
  - the response record layout (valid, error, offset, size, unsigned).
- One sub-module, dmem_load_align: combinational shift plus sign/zero extension from word, offset, size and unsigned to read_data. It is reused by the MMIO read path.
- Storage array, lane-enable generation, FSM and latency pipeline stay in dmem_sized.

Test Plan:
- CLEAR_ON_RESET=1, ADDR_WIDTH=4 -> req_ready low exactly 16 cycles after reset release; loads of words 0..15 all return 0x00000000.
- Store word 0x8844_22FF @0x10, then byte loads @0x10..0x13 signed -> 0xFFFFFFFF, 0x00000022, 0x00000044, 0xFFFFFF88. Same loads unsigned -> 0x000000FF, 0x22, 0x44, 0x88.
- Store byte 0xAB @0x21 over word 0x11223344 -> word load @0x20 returns 0x1122AB44. Store half 0x8000 @0x22 -> signed half load @0x22 returns 0xFFFF8000.
- Misaligned: word store @0x13 and half load @0x15 -> resp_error=1, read_data=0; word @0x10 is unchanged. Size 11 also gives an error.
- READ_LATENCY=3, back-to-back requests on 4 consecutive cycles -> 4 resp_valid pulses on cycles accept+3, in order. Store followed next cycle by a load to the same word returns the stored value.
- Reset asserted with 2 loads in flight -> no resp_valid after reset. Reset mid-CLEAR -> sweep restarts and req_ready stays low a full 2**ADDR_WIDTH cycles.
